// File: rtl/wb_dma_copy.sv
// wb_dma_copy: single-channel Wishbone copy engine. Moves len 32-bit words
// from a source to a destination address, one read followed by one write per
// word, with retry handling, error abort and a graceful stop request.
module wb_dma_copy #(
    parameter int LEN_W   = 16,
    parameter int RTY_MAX = 15
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [31:0]      src_addr_i,
    input  logic [31:0]      dst_addr_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [LEN_W-1:0] words_done_o,
    output logic [31:0]      wb_adr_o,
    output logic [31:0]      wb_dat_o,
    input  logic [31:0]      wb_dat_i,
    output logic [3:0]       wb_sel_o,
    output logic             wb_we_o,
    output logic             wb_stb_o,
    output logic             wb_cyc_o,
    input  logic             wb_ack_i,
    input  logic             wb_err_i,
    input  logic             wb_rty_i
);

    localparam int RTY_W = $clog2(RTY_MAX + 2);

    typedef enum logic [2:0] {IDLE, RD, RD_GAP, WR, WR_GAP} state_t;

    state_t           state;
    logic [31:0]      src;
    logic [31:0]      dst;
    logic [31:0]      data_buf;
    logic [LEN_W-1:0] len;
    logic [RTY_W-1:0] rty_cnt;
    logic             retry;
    logic             abort_pend;
    logic             stop;
    logic             rty_over;
    logic             finish;
    logic             fail;

    // A stop request is either remembered from earlier in the transfer or arriving now.
    assign stop     = abort_pend | abort_i;
    assign rty_over = (rty_cnt == RTY_W'(RTY_MAX));

    // Decide whether this edge ends the transfer, normally (finish) or with an error (fail).
    always_comb begin
        finish = 1'b0;
        fail   = 1'b0;
        case (state)
            RD, WR: begin
                if (wb_err_i) begin
                    fail = 1'b1;
                end else if (wb_ack_i) begin
                    finish = stop;
                end else if (wb_rty_i) begin
                    if (rty_over) fail = 1'b1;
                    else          finish = stop;
                end
            end
            RD_GAP:  finish = stop;
            WR_GAP:  finish = stop || !(words_done_o < len);
            default: begin
                finish = 1'b0;
                fail   = 1'b0;
            end
        endcase
    end

    // Transfer state machine; every output is registered here.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state        <= IDLE;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            words_done_o <= '0;
            wb_adr_o     <= '0;
            wb_dat_o     <= '0;
            wb_sel_o     <= '0;
            wb_we_o      <= 1'b0;
            wb_stb_o     <= 1'b0;
            wb_cyc_o     <= 1'b0;
            rty_cnt      <= '0;
            retry        <= 1'b0;
            abort_pend   <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (busy_o && abort_i) abort_pend <= 1'b1;

            case (state)
                IDLE: begin
                    // A start in the same cycle as the done pulse is deliberately dropped.
                    if (start_i && !done_o) begin
                        src          <= {src_addr_i[31:2], 2'b00};
                        dst          <= {dst_addr_i[31:2], 2'b00};
                        len          <= len_i;
                        err_o        <= 1'b0;
                        words_done_o <= '0;
                        rty_cnt      <= '0;
                        retry        <= 1'b0;
                        abort_pend   <= 1'b0;
                        if (len_i == '0) begin
                            done_o <= 1'b1;
                        end else begin
                            state    <= RD;
                            busy_o   <= 1'b1;
                            wb_cyc_o <= 1'b1;
                            wb_stb_o <= 1'b1;
                            wb_we_o  <= 1'b0;
                            wb_sel_o <= 4'hF;
                            wb_adr_o <= {src_addr_i[31:2], 2'b00};
                        end
                    end
                end
                RD: begin
                    if (!wb_err_i && wb_ack_i) begin
                        data_buf <= wb_dat_i;
                        rty_cnt  <= '0;
                        retry    <= 1'b0;
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        state    <= RD_GAP;
                    end else if (!wb_err_i && wb_rty_i) begin
                        rty_cnt  <= rty_cnt + RTY_W'(1);
                        retry    <= 1'b1;
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        state    <= RD_GAP;
                    end
                end
                RD_GAP: begin
                    wb_cyc_o <= 1'b1;
                    wb_stb_o <= 1'b1;
                    if (retry) begin
                        state <= RD;
                    end else begin
                        state    <= WR;
                        wb_we_o  <= 1'b1;
                        wb_adr_o <= dst;
                        wb_dat_o <= data_buf;
                    end
                end
                WR: begin
                    if (!wb_err_i && wb_ack_i) begin
                        words_done_o <= words_done_o + LEN_W'(1);
                        src          <= src + 32'd4;
                        dst          <= dst + 32'd4;
                        rty_cnt      <= '0;
                        retry        <= 1'b0;
                        wb_cyc_o     <= 1'b0;
                        wb_stb_o     <= 1'b0;
                        state        <= WR_GAP;
                    end else if (!wb_err_i && wb_rty_i) begin
                        rty_cnt  <= rty_cnt + RTY_W'(1);
                        retry    <= 1'b1;
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        state    <= WR_GAP;
                    end
                end
                WR_GAP: begin
                    wb_cyc_o <= 1'b1;
                    wb_stb_o <= 1'b1;
                    if (retry) begin
                        state <= WR;
                    end else begin
                        state    <= RD;
                        wb_we_o  <= 1'b0;
                        wb_adr_o <= src;
                    end
                end
                default: state <= IDLE;
            endcase

            // Ending the transfer overrides whatever the state decoded above.
            if (finish || fail) begin
                state    <= IDLE;
                busy_o   <= 1'b0;
                done_o   <= 1'b1;
                wb_cyc_o <= 1'b0;
                wb_stb_o <= 1'b0;
                wb_we_o  <= 1'b0;
                wb_sel_o <= 4'h0;
                if (fail) err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_dma_copy.sv
// tb_wb_dma_copy: randomized bench for wb_dma_copy with a behavioural Wishbone
// slave and a word-level reference model of the copy.
module tb_wb_dma_copy;

    localparam int LEN_W   = 16;
    localparam int RTY_MAX = 15;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [31:0]      src_addr = '0;
    logic [31:0]      dst_addr = '0;
    logic [LEN_W-1:0] len = '0;
    logic             busy_o, done_o, err_o;
    logic [LEN_W-1:0] words_done_o;
    logic [31:0]      wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]       wb_sel_o;
    logic             wb_we_o, wb_stb_o, wb_cyc_o;
    logic             wb_ack_i, wb_err_i, wb_rty_i;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wb_dma_copy #(.LEN_W(LEN_W), .RTY_MAX(RTY_MAX)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .abort_i(abort),
        .src_addr_i(src_addr), .dst_addr_i(dst_addr), .len_i(len),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .words_done_o(words_done_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o),
        .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
    );

    // Slave configuration, written only by the test sequence
    int          wait_states = 0;
    int          rd_rty_cfg  = 0;
    int          err_on_wr   = 0;
    logic [31:0] seed        = 32'h1234_5678;

    // Slave state, written only by the slave process
    int attempt   = 0;
    int rty_given = 0;
    int wr_resp_n = 0;
    int cyc_count = 0;
    int cyc_hi    = 0;

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [31:0] dat;
        int          kind;   // 0 ack, 1 err, 2 rty
        int          cyc;
    } txn_t;
    txn_t log_q[$];

    logic [31:0] exp_adr[$];
    logic        exp_we[$];
    logic [31:0] exp_dat[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ seed;
    endfunction

    // Reference model: word i reads src+4i and writes that word to dst+4i.
    function automatic void build_model(input logic [31:0] s, input logic [31:0] d, input int n);
        logic [31:0] sa, da;
        exp_adr.delete(); exp_we.delete(); exp_dat.delete();
        sa = s & 32'hFFFF_FFFC;
        da = d & 32'hFFFF_FFFC;
        for (int i = 0; i < n; i++) begin
            exp_adr.push_back(sa + 32'(4 * i)); exp_we.push_back(1'b0); exp_dat.push_back(32'h0);
            exp_adr.push_back(da + 32'(4 * i)); exp_we.push_back(1'b1); exp_dat.push_back(mem_word(sa + 32'(4 * i)));
        end
    endfunction

    logic req, resp;
    always @* begin
        req      = wb_cyc_o && wb_stb_o;
        resp     = req && (attempt >= wait_states);
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_rty_i = 1'b0;
        if (resp) begin
            if (!wb_we_o && rty_given < rd_rty_cfg)        wb_rty_i = 1'b1;
            else if (wb_we_o && err_on_wr == wr_resp_n + 1) wb_err_i = 1'b1;
            else                                            wb_ack_i = 1'b1;
        end
        wb_dat_i = mem_word(wb_adr_o);
    end

    always @(posedge clk) begin
        cyc_count <= cyc_count + 1;
        if (wb_cyc_o) cyc_hi <= cyc_hi + 1;
        if (req && !resp) attempt <= attempt + 1;
        else              attempt <= 0;
        if (!busy_o) begin
            rty_given <= 0;
            wr_resp_n <= 0;
        end else if (resp) begin
            if (wb_rty_i) rty_given <= rty_given + 1;
            if (wb_we_o)  wr_resp_n <= wr_resp_n + 1;
        end
        if (resp)
            log_q.push_back(txn_t'{adr: wb_adr_o, we: wb_we_o, dat: wb_dat_o,
                                   kind: (wb_err_i ? 1 : (wb_ack_i ? 0 : 2)), cyc: cyc_count});
    end

    task automatic do_start(input logic [31:0] s, input logic [31:0] d, input int n, output int t0);
        src_addr = s; dst_addr = d; len = LEN_W'(n); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc_count;
    endtask

    task automatic wait_done(input int limit, output int at, output bit ok);
        ok = 1'b0; at = 0;
        for (int i = 0; i < limit; i++) begin
            if (done_o) begin ok = 1'b1; at = cyc_count; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy_o !== 1'b0)       begin errors++; $display("FAIL rst_busy got %0b want 0", busy_o); end
        checks++; if (done_o !== 1'b0)       begin errors++; $display("FAIL rst_done got %0b want 0", done_o); end
        checks++; if (err_o !== 1'b0)        begin errors++; $display("FAIL rst_err got %0b want 0", err_o); end
        checks++; if (words_done_o !== '0)   begin errors++; $display("FAIL rst_words got %0d want 0", words_done_o); end
        checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b000) begin errors++; $display("FAIL rst_ctl got %b want 000", {wb_cyc_o, wb_stb_o, wb_we_o}); end
        checks++; if (wb_adr_o !== 32'h0 || wb_dat_o !== 32'h0 || wb_sel_o !== 4'h0) begin
            errors++; $display("FAIL rst_bus got adr=%h dat=%h sel=%h want zeros", wb_adr_o, wb_dat_o, wb_sel_o); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int t0, at, base, k; bit ok;
        wait_states = 0; seed = $urandom;
        base = log_q.size();
        build_model(32'h3000_0000, 32'h0000_1000, 3);
        do_start(32'h3000_0000, 32'h0000_1000, 3, t0);
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL basic_busy got %0b want 1", busy_o); end
        wait_done(200, at, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_timeout got no done want done"); end
        checks++; if (at - t0 + 1 !== 13) begin errors++; $display("FAIL basic_done_cycle got %0d want 13", at - t0 + 1); end
        checks++; if (words_done_o !== 16'd3 || err_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL basic_status got words=%0d err=%0b busy=%0b want 3 0 0", words_done_o, err_o, busy_o); end
        k = 0;
        for (int j = base; j < log_q.size(); j++) if (log_q[j].kind == 0) begin
            checks++;
            if (k >= exp_adr.size() || log_q[j].adr !== exp_adr[k] || log_q[j].we !== exp_we[k] || (exp_we[k] && log_q[j].dat !== exp_dat[k])) begin
                errors++; $display("FAIL basic_txn%0d got adr=%h we=%0b dat=%h want adr=%h we=%0b dat=%h", k, log_q[j].adr, log_q[j].we, log_q[j].dat, exp_adr[k], exp_we[k], exp_dat[k]); end
            k++;
        end
        checks++; if (k !== exp_adr.size()) begin errors++; $display("FAIL basic_txn_count got %0d want %0d", k, exp_adr.size()); end
        @(negedge clk);
    endtask

    task automatic test_random_copies;
        int t0, at, base, k, n, w; bit ok; logic [31:0] s, d;
        for (int it = 0; it < 5; it++) begin
            s = (it == 0) ? 32'hFFFF_FFF9 : $urandom;
            d = $urandom;
            n = (it == 0) ? 3 : $urandom_range(1, 5);
            w = $urandom_range(0, 3);
            wait_states = w; seed = $urandom;
            base = log_q.size();
            build_model(s, d, n);
            do_start(s, d, n, t0);
            wait_done(500, at, ok);
            checks++; if (!ok) begin errors++; $display("FAIL rand%0d_timeout got no done want done", it); end
            checks++; if (at - t0 + 1 !== n * (2 * w + 4) + 1) begin
                errors++; $display("FAIL rand%0d_done_cycle got %0d want %0d", it, at - t0 + 1, n * (2 * w + 4) + 1); end
            checks++; if (words_done_o !== LEN_W'(n) || err_o !== 1'b0) begin
                errors++; $display("FAIL rand%0d_status got words=%0d err=%0b want %0d 0", it, words_done_o, err_o, n); end
            k = 0;
            for (int j = base; j < log_q.size(); j++) if (log_q[j].kind == 0) begin
                checks++;
                if (k >= exp_adr.size() || log_q[j].adr !== exp_adr[k] || log_q[j].we !== exp_we[k] || (exp_we[k] && log_q[j].dat !== exp_dat[k])) begin
                    errors++; $display("FAIL rand%0d_txn%0d got adr=%h we=%0b dat=%h want adr=%h we=%0b dat=%h", it, k, log_q[j].adr, log_q[j].we, log_q[j].dat, exp_adr[k], exp_we[k], exp_dat[k]); end
                k++;
            end
            checks++; if (k !== exp_adr.size()) begin errors++; $display("FAIL rand%0d_txn_count got %0d want %0d", it, k, exp_adr.size()); end
            @(negedge clk);
        end
        wait_states = 0;
    endtask

    task automatic test_unaligned_len0;
        int t0, at, base, hi0; bit ok;
        base = log_q.size();
        do_start(32'h3000_0002, 32'h0000_0203, 1, t0);
        wait_done(100, at, ok);
        checks++; if (!ok || log_q.size() < base + 2) begin errors++; $display("FAIL unal_timeout got %0d txns want 2", log_q.size() - base); end
        else begin
            checks++; if (log_q[base].adr !== 32'h3000_0000) begin errors++; $display("FAIL unal_rd_adr got %h want 30000000", log_q[base].adr); end
            checks++; if (log_q[base + 1].adr !== 32'h0000_0200) begin errors++; $display("FAIL unal_wr_adr got %h want 00000200", log_q[base + 1].adr); end
        end
        @(negedge clk);
        hi0 = cyc_hi;
        do_start(32'h4000_0000, 32'h5000_0000, 0, t0);
        checks++; if (done_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL len0_done got done=%0b busy=%0b want 1 0", done_o, busy_o); end
        @(negedge clk);
        checks++; if (cyc_hi !== hi0 || done_o !== 1'b0) begin errors++; $display("FAIL len0_cyc got cyc_cycles=%0d done=%0b want 0 0", cyc_hi - hi0, done_o); end
    endtask

    task automatic test_retry;
        int t0, at, base, k; bit ok;
        seed = $urandom; rd_rty_cfg = 2;
        base = log_q.size();
        build_model(32'h0000_8000, 32'h0000_9000, 2);
        do_start(32'h0000_8000, 32'h0000_9000, 2, t0);
        wait_done(200, at, ok);
        checks++; if (!ok || log_q.size() < base + 3) begin errors++; $display("FAIL rty_timeout got %0d txns want 3+", log_q.size() - base); end
        else begin
            checks++; if (log_q[base].kind !== 2 || log_q[base + 1].kind !== 2 || log_q[base + 2].kind !== 0) begin
                errors++; $display("FAIL rty_kinds got %0d %0d %0d want 2 2 0", log_q[base].kind, log_q[base + 1].kind, log_q[base + 2].kind); end
            checks++; if (log_q[base + 1].adr !== 32'h0000_8000 || log_q[base + 2].adr !== 32'h0000_8000 || log_q[base + 2].we !== 1'b0) begin
                errors++; $display("FAIL rty_same_req got %h %h want 00008000", log_q[base + 1].adr, log_q[base + 2].adr); end
            checks++; if (log_q[base + 1].cyc - log_q[base].cyc !== 2 || log_q[base + 2].cyc - log_q[base + 1].cyc !== 2) begin
                errors++; $display("FAIL rty_spacing got %0d %0d want 2 2", log_q[base + 1].cyc - log_q[base].cyc, log_q[base + 2].cyc - log_q[base + 1].cyc); end
        end
        k = 0;
        for (int j = base; j < log_q.size(); j++) if (log_q[j].kind == 0) begin
            checks++;
            if (k >= exp_adr.size() || log_q[j].adr !== exp_adr[k] || log_q[j].we !== exp_we[k] || (exp_we[k] && log_q[j].dat !== exp_dat[k])) begin
                errors++; $display("FAIL rty_txn%0d got adr=%h dat=%h want adr=%h dat=%h", k, log_q[j].adr, log_q[j].dat, exp_adr[k], exp_dat[k]); end
            k++;
        end
        checks++; if (words_done_o !== 16'd2 || err_o !== 1'b0) begin errors++; $display("FAIL rty_status got words=%0d err=%0b want 2 0", words_done_o, err_o); end
        @(negedge clk);
        rd_rty_cfg = RTY_MAX + 1;
        base = log_q.size();
        do_start(32'h0000_8000, 32'h0000_9000, 2, t0);
        wait_done(300, at, ok);
        checks++; if (!ok || err_o !== 1'b1 || words_done_o !== 16'd0) begin
            errors++; $display("FAIL rty_over got done=%0b err=%0b words=%0d want 1 1 0", ok, err_o, words_done_o); end
        k = 0;
        for (int j = base; j < log_q.size(); j++) if (log_q[j].kind == 2) k++;
        checks++; if (k !== RTY_MAX + 1 || log_q.size() - base !== RTY_MAX + 1) begin
            errors++; $display("FAIL rty_over_count got rty=%0d total=%0d want %0d", k, log_q.size() - base, RTY_MAX + 1); end
        rd_rty_cfg = 0;
        @(negedge clk);
    endtask

    task automatic test_write_err;
        int t0, at, base; bit ok;
        err_on_wr = 2;
        base = log_q.size();
        do_start(32'h0001_0000, 32'h0002_0000, 4, t0);
        wait_done(200, at, ok);
        checks++; if (!ok || err_o !== 1'b1 || words_done_o !== 16'd1) begin
            errors++; $display("FAIL werr_status got done=%0b err=%0b words=%0d want 1 1 1", ok, err_o, words_done_o); end
        checks++; if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL werr_cyc got cyc=%0b stb=%0b busy=%0b want 0 0 0", wb_cyc_o, wb_stb_o, busy_o); end
        checks++; if (log_q.size() !== base + 4 || log_q[log_q.size() - 1].kind !== 1 || at - log_q[log_q.size() - 1].cyc !== 1) begin
            errors++; $display("FAIL werr_seq got txns=%0d want 4 ending in err one cycle before done", log_q.size() - base); end
        err_on_wr = 0;
        @(negedge clk);
    endtask

    task automatic test_abort;
        int t0, at, base, rd, wr; bit ok, hit;
        wait_states = 5;
        base = log_q.size();
        do_start(32'h0004_0000, 32'h0005_0000, 8, t0);
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            if (wb_stb_o && !wb_we_o && words_done_o == 16'd2) hit = 1'b1;
            else @(negedge clk);
        end
        checks++; if (!hit) begin errors++; $display("FAIL abort_rd_reach got no third read want third read"); end
        abort = 1'b1; @(negedge clk); abort = 1'b0;
        wait_done(200, at, ok);
        rd = 0; wr = 0;
        for (int j = base; j < log_q.size(); j++) if (log_q[j].kind == 0) begin if (log_q[j].we) wr++; else rd++; end
        checks++; if (!ok || err_o !== 1'b0 || words_done_o !== 16'd2) begin
            errors++; $display("FAIL abort_rd_status got done=%0b err=%0b words=%0d want 1 0 2", ok, err_o, words_done_o); end
        checks++; if (rd !== 3 || wr !== 2) begin errors++; $display("FAIL abort_rd_txns got rd=%0d wr=%0d want 3 2", rd, wr); end
        @(negedge clk);
        checks++; if (wb_cyc_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL abort_rd_idle got cyc=%0b busy=%0b want 0 0", wb_cyc_o, busy_o); end
        wait_states = 2;
        base = log_q.size();
        do_start(32'h0006_0000, 32'h0007_0000, 4, t0);
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            if (wb_stb_o && wb_we_o) hit = 1'b1;
            else @(negedge clk);
        end
        abort = 1'b1; @(negedge clk); abort = 1'b0;
        wait_done(100, at, ok);
        wr = 0;
        for (int j = base; j < log_q.size(); j++) if (log_q[j].kind == 0 && log_q[j].we) wr++;
        checks++; if (!hit || !ok || words_done_o !== 16'd1 || wr !== 1) begin
            errors++; $display("FAIL abort_wr got done=%0b words=%0d writes=%0d want 1 1 1", ok, words_done_o, wr); end
        wait_states = 0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int t0, at, base, wr; bit ok, hit;
        wait_states = 3;
        do_start(32'h0008_0000, 32'h0009_0000, 4, t0);
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            if (wb_stb_o && wb_we_o) hit = 1'b1;
            else @(negedge clk);
        end
        rst = 1'b1; @(negedge clk);
        checks++; if (!hit || wb_stb_o !== 1'b0 || wb_cyc_o !== 1'b0 || busy_o !== 1'b0 || words_done_o !== '0) begin
            errors++; $display("FAIL rstmid got stb=%0b cyc=%0b busy=%0b words=%0d want 0 0 0 0", wb_stb_o, wb_cyc_o, busy_o, words_done_o); end
        rst = 1'b0; wait_states = 0;
        repeat (2) @(negedge clk);
        base = log_q.size();
        do_start(32'h000A_0000, 32'h000B_0000, 3, t0);
        wait_done(100, at, ok);
        wr = 0;
        for (int j = base; j < log_q.size(); j++) if (log_q[j].kind == 0 && log_q[j].we) wr++;
        checks++; if (!ok || at - t0 + 1 !== 13 || words_done_o !== 16'd3 || wr !== 3) begin
            errors++; $display("FAIL rstmid_rerun got done=%0b cycle=%0d words=%0d writes=%0d want 1 13 3 3", ok, at - t0 + 1, words_done_o, wr); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int t0, at, hi0; bit ok;
        do_start(32'h000C_0000, 32'h000D_0000, 1, t0);
        wait_done(50, at, ok);
        hi0 = cyc_hi;
        do_start(32'h000E_0000, 32'h000F_0000, 2, t0);
        checks++; if (!ok || busy_o !== 1'b0 || cyc_hi !== hi0) begin
            errors++; $display("FAIL b2b_ignored got busy=%0b cyc_cycles=%0d want 0 0", busy_o, cyc_hi - hi0); end
        do_start(32'h000E_0000, 32'h000F_0000, 2, t0);
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy=%0b want 1", busy_o); end
        wait_done(100, at, ok);
        checks++; if (!ok || words_done_o !== 16'd2) begin errors++; $display("FAIL b2b_words got done=%0b words=%0d want 1 2", ok, words_done_o); end
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_random_copies();
        test_unaligned_len0();
        test_retry();
        test_write_err();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
